phs_arbiter: RTL

PHS_ARBITER -- requirements
Module: phs_arbiter

---
 rtl/phs_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/phs_arbiter.sv
// Multi-lane packet-header-summary arbiter: per-lane holding FIFOs, round-robin
// grant and a single registered output with valid/ready handshake.
module phs_arbiter #(
  parameter int NUM_LANES  = 4,
  parameter int PHS_WIDTH  = 120,
  parameter int LANE_DEPTH = 2
) (
  input  logic                           CLK,
  input  logic                           reset,
  input  logic [NUM_LANES*PHS_WIDTH-1:0] phs_i,
  input  logic [NUM_LANES-1:0]           phs_valid_i,
  output logic [PHS_WIDTH-1:0]           phs_o,
  output logic                           phs_valid_o,
  input  logic                           phs_ready_i,
  output logic [2:0]                     lane_o,
  output logic [NUM_LANES*16-1:0]        drop_cnt_o
);

  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int PW = (LANE_DEPTH > 1) ? $clog2(LANE_DEPTH) : 1;
  localparam int CW = $clog2(LANE_DEPTH + 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [NUM_LANES-1:0]   nonempty;
  logic [NUM_LANES-1:0]   pop;
  logic [PHS_WIDTH-1:0]   head [NUM_LANES];
  logic [LW-1:0]          last_grant_q;
  logic [LW-1:0]          grant_idx;
  logic                   grant_found;
  logic                   load;
  logic [PHS_WIDTH-1:0]   phs_q;
  logic [LW-1:0]          lane_q;
  int                     j;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [PHS_WIDTH-1:0] mem [LANE_DEPTH];
    logic [PW-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]        count_q;
    logic [15:0]          drop_q;
    logic                 full, push, drop;

    // A full lane still accepts a pulse when its head leaves in the same cycle.
    assign full = (count_q == CW'(LANE_DEPTH));
    assign push = phs_valid_i[k] && (!full || pop[k]);
    assign drop = phs_valid_i[k] && full && !pop[k];

    // NOTE: storage is deliberately not reset; count_q alone says which entries are live.
    always_ff @(posedge CLK) begin
      if (push) mem[wr_ptr_q] <= phs_i[k*PHS_WIDTH +: PHS_WIDTH];
    end

    always_ff @(posedge CLK) begin
      if (reset) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        drop_q   <= '0;
      end else begin
        if (push) wr_ptr_q <= (wr_ptr_q == PW'(LANE_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop[k]) rd_ptr_q <= (rd_ptr_q == PW'(LANE_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop[k]})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (drop && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end

    assign nonempty[k]            = (count_q != '0);
    assign head[k]                = mem[rd_ptr_q];
    assign drop_cnt_o[k*16 +: 16] = drop_q;
  end

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 1; i <= NUM_LANES; i++) begin
      j = (int'(last_grant_q) + i) % NUM_LANES;
      if (!grant_found && nonempty[LW'(j)]) begin
        grant_found = 1'b1;
        grant_idx   = LW'(j);
      end
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (phs_ready_i) begin
          if (grant_found) load = 1'b1;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pop = load ? (NUM_LANES'(1) << grant_idx) : '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      phs_q        <= '0;
      lane_q       <= '0;
      last_grant_q <= LW'(NUM_LANES - 1);
    end else begin
      state_q <= state_d;
      if (load) begin
        phs_q        <= head[grant_idx];
        lane_q       <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

  assign phs_o       = phs_q;
  assign phs_valid_o = (state_q == HOLD);
  assign lane_o      = 3'(lane_q);

endmodule
